// File: rtl/ps2_cmd_pkg.sv
// Shared scancodes, command codes, held-bit indices and decoder state type for
// the PS/2 keyboard command path.
package ps2_cmd_pkg;

  localparam logic [7:0] ScExt      = 8'hE0;
  localparam logic [7:0] ScBrk      = 8'hF0;
  localparam logic [7:0] ScUpExt    = 8'h75;
  localparam logic [7:0] ScDownExt  = 8'h72;
  localparam logic [7:0] ScLeftExt  = 8'h6B;
  localparam logic [7:0] ScRightExt = 8'h74;
  localparam logic [7:0] ScW        = 8'h1D;
  localparam logic [7:0] ScS        = 8'h1B;
  localparam logic [7:0] ScA        = 8'h1C;
  localparam logic [7:0] ScD        = 8'h23;
  localparam logic [7:0] ScEnter    = 8'h5A;
  localparam logic [7:0] ScP        = 8'h4D;

  localparam logic [2:0] CmdUp    = 3'd1;
  localparam logic [2:0] CmdDown  = 3'd2;
  localparam logic [2:0] CmdLeft  = 3'd3;
  localparam logic [2:0] CmdRight = 3'd4;
  localparam logic [2:0] CmdStart = 3'd5;
  localparam logic [2:0] CmdPause = 3'd6;

  localparam logic [2:0] HeldUp    = 3'd0;
  localparam logic [2:0] HeldDown  = 3'd1;
  localparam logic [2:0] HeldLeft  = 3'd2;
  localparam logic [2:0] HeldRight = 3'd3;
  localparam logic [2:0] HeldStart = 3'd4;
  localparam logic [2:0] HeldPause = 3'd5;

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} dec_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_hit_t;

  // Command code for a held bit is always its index plus one.
  function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] b);
    key_hit_t k;
    k.hit = 1'b1;
    k.idx = HeldUp;
    if (ext) begin
      case (b)
        ScUpExt:    k.idx = HeldUp;
        ScDownExt:  k.idx = HeldDown;
        ScLeftExt:  k.idx = HeldLeft;
        ScRightExt: k.idx = HeldRight;
        default:    k.hit = 1'b0;
      endcase
    end else begin
      case (b)
        ScW:     k.idx = HeldUp;
        ScS:     k.idx = HeldDown;
        ScA:     k.idx = HeldLeft;
        ScD:     k.idx = HeldRight;
        ScEnter: k.idx = HeldStart;
        ScP:     k.idx = HeldPause;
        default: k.hit = 1'b0;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small circular command FIFO with combinational head read and a sticky
// overflow flag; a push into a full FIFO survives only if a pop frees a slot.
module cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
    if (push_i && !do_push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o    = empty ? '0 : mem_q[rd_ptr_q];
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_key_cmd_ctrl.sv
// Decodes PS/2 make/break/extended byte sequences into game commands, tracks
// held control keys, drops typematic repeats and queues fresh presses.
module ps2_key_cmd_ctrl
  import ps2_cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CMD_W      = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          key_pressed_in,
  input  logic [7:0]                    key_data_in,
  output logic                          cmd_valid,
  output logic [CMD_W-1:0]              cmd_data,
  input  logic                          cmd_ready,
  output logic [5:0]                    held,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  dec_state_e state_q, state_d;
  logic [5:0] held_q, held_d;
  key_hit_t   key;
  logic       push;
  logic       empty;

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    push    = 1'b0;
    key     = key_lookup((state_q == StExt) || (state_q == StExtBrk), key_data_in);
    if (key_pressed_in) begin
      if (key_data_in == ScExt) begin
        state_d = StExt;
      end else if (key_data_in == ScBrk) begin
        unique case (state_q)
          StIdle:  state_d = StBrk;
          StExt:   state_d = StExtBrk;
          default: state_d = state_q;
        endcase
      end else begin
        state_d = StIdle;
        if (key.hit) begin
          if ((state_q == StBrk) || (state_q == StExtBrk)) begin
            held_d[key.idx] = 1'b0;
          end else if (!held_q[key.idx]) begin
            // Only a fresh press queues; a held key's typematic repeat is dropped.
            held_d[key.idx] = 1'b1;
            push            = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  cmd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (CMD_W)
  ) u_cmd_fifo (
    .clk_i      (clock),
    .rst_i      (reset),
    .push_i     (push),
    .wdata_i    (CMD_W'(key.idx + 3'd1)),
    .pop_i      (cmd_ready),
    .rdata_o    (cmd_data),
    .empty_o    (empty),
    .count_o    (fifo_count),
    .overflow_o (overflow)
  );

  assign cmd_valid = ~empty;
  assign held      = held_q;

endmodule

// File: tb/tb_ps2_key_cmd_ctrl.sv
// Directed bench for ps2_key_cmd_ctrl: byte sequences with hand-computed
// command, held, count and overflow expectations.
module tb_ps2_key_cmd_ctrl;
  import ps2_cmd_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_pressed_in;
  logic [7:0] key_data_in;
  logic       cmd_valid;
  logic [2:0] cmd_data;
  logic       cmd_ready;
  logic [5:0] held;
  logic [2:0] fifo_count;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  ps2_key_cmd_ctrl #(
    .FIFO_DEPTH (4),
    .CMD_W      (3)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .key_pressed_in (key_pressed_in),
    .key_data_in    (key_data_in),
    .cmd_valid      (cmd_valid),
    .cmd_data       (cmd_data),
    .cmd_ready      (cmd_ready),
    .held           (held),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe one byte; returns on the falling edge after the capturing edge.
  task automatic send(input logic [7:0] b);
    @(negedge clock);
    key_pressed_in = 1'b1;
    key_data_in    = b;
    @(negedge clock);
    key_pressed_in = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clock);
    cmd_ready = 1'b1;
    @(negedge clock);
    cmd_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic fill_wasd();
    send(8'h1D); send(8'hF0); send(8'h1D);
    send(8'h1B); send(8'hF0); send(8'h1B);
    send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'h23); send(8'hF0); send(8'h23);
  endtask

  initial begin
    logic [2:0] exp_drain [4];
    reset          = 1'b1;
    key_pressed_in = 1'b0;
    key_data_in    = 8'h00;
    cmd_ready      = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    check("rst_held", 32'(held), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_data", 32'(cmd_data), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // 1: plain make then break
    send(8'h1D);
    check("t1_valid", 32'(cmd_valid), 32'd1);
    check("t1_data", 32'(cmd_data), 32'd1);
    check("t1_held_make", 32'(held), 32'h01);
    send(8'hF0);
    check("t1_held_f0", 32'(held), 32'h01);
    send(8'h1D);
    check("t1_held_brk", 32'(held), 32'h00);
    check("t1_count", 32'(fifo_count), 32'd1);
    pop_one();
    check("t1_drained", 32'(fifo_count), 32'd0);

    // 2: extended make, repeat, extended break
    send(8'hE0); send(8'h6B);
    check("t2_held_make", 32'(held), 32'h04);
    check("t2_data", 32'(cmd_data), 32'd3);
    send(8'hE0); send(8'h6B);
    check("t2_count_rep", 32'(fifo_count), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("t2_held_brk", 32'(held), 32'h00);
    check("t2_count", 32'(fifo_count), 32'd1);
    pop_one();

    // 3: overflow on fifth fresh make
    fill_wasd();
    check("t3_count4", 32'(fifo_count), 32'd4);
    check("t3_ovf_before", 32'(overflow), 32'd0);
    send(8'h5A);
    check("t3_count_full", 32'(fifo_count), 32'd4);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_held_start", 32'(held), 32'h10);
    send(8'hF0); send(8'h5A);
    check("t3_held_clr", 32'(held), 32'h00);
    exp_drain = '{3'd1, 3'd2, 3'd3, 3'd4};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_drain%0d", i), 32'(cmd_data), 32'(exp_drain[i]));
      pop_one();
    end
    check("t3_empty_valid", 32'(cmd_valid), 32'd0);
    check("t3_empty_data", 32'(cmd_data), 32'd0);

    // 4: push and pop together while full
    fill_wasd();
    @(negedge clock);
    key_pressed_in = 1'b1;
    key_data_in    = 8'h4D;
    cmd_ready      = 1'b1;
    @(negedge clock);
    key_pressed_in = 1'b0;
    cmd_ready      = 1'b0;
    check("t4_count", 32'(fifo_count), 32'd4);
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_head", 32'(cmd_data), 32'd2);
    check("t4_held", 32'(held), 32'h20);
    exp_drain = '{3'd2, 3'd3, 3'd4, 3'd6};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_drain%0d", i), 32'(cmd_data), 32'(exp_drain[i]));
      pop_one();
    end
    check("t4_empty", 32'(cmd_valid), 32'd0);

    // 5: reset after E0 makes the next byte plain
    send(8'hE0);
    pulse_reset();
    check("t5_ovf_rst", 32'(overflow), 32'd0);
    send(8'h75);
    check("t5_count", 32'(fifo_count), 32'd0);
    check("t5_valid", 32'(cmd_valid), 32'd0);
    check("t5_held", 32'(held), 32'h00);
    check("t5_state", 32'(dut.state_q), 32'(StIdle));

    // 6: E0-prefixed start and an unmapped byte are ignored
    send(8'hE0); send(8'h5A);
    check("t6_count_e0", 32'(fifo_count), 32'd0);
    check("t6_held_e0", 32'(held), 32'h00);
    check("t6_state", 32'(dut.state_q), 32'(StIdle));
    send(8'h2C);
    check("t6_count_unm", 32'(fifo_count), 32'd0);
    check("t6_held_unm", 32'(held), 32'h00);
    send(8'h1D);
    check("t6_valid", 32'(cmd_valid), 32'd1);
    check("t6_data", 32'(cmd_data), 32'd1);
    check("t6_count", 32'(fifo_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
